// File: rtl/hack_pkg.sv
// Shared Hack-platform definitions used by the register write arbiter.
package hack_pkg;

    localparam int HACK_WORD_W = 16;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Round-robin winner search: first request not masked, scanning upward from
// start_i with wrap-around.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [N-1:0]  mask_i,
    input  logic [IW-1:0] start_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);

    int j;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        j       = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(start_i) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!found_o && req_i[j] && !mask_i[j]) begin
                found_o = 1'b1;
                idx_o   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter sharing one Hack register between NUM_REQ
// requesters, with locked bursts capped at MAX_LOCK consecutive writes.
module reg_write_arbiter
    import hack_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int WIDTH    = HACK_WORD_W,
    parameter int MAX_LOCK = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_lock,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       grant_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic [WIDTH-1:0]           reg_in,
    output logic                       reg_load
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    arb_state_e       state_q;
    logic [IDW-1:0]   grant_q;
    logic [IDW-1:0]   ptr_q;
    logic [7:0]       lock_cnt_q;

    logic             in_grant;
    logic             handshake;
    logic             stay_locked;
    logic [IDW-1:0]   next_ptr;
    logic [IDW-1:0]   pick_start;
    logic [NUM_REQ-1:0] pick_mask;
    logic             pick_found;
    logic [IDW-1:0]   pick_idx;

    assign in_grant    = (state_q == ARB_GRANT);
    assign handshake   = in_grant && req_valid[grant_q];
    assign stay_locked = handshake && req_lock[grant_q] && (lock_cnt_q < 8'(MAX_LOCK - 1));
    assign next_ptr    = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + IDW'(1);

    // While granted, the current owner is excluded and the search starts
    // just after it, so a busy requester cannot re-win without a lock.
    assign pick_start  = in_grant ? next_ptr : ptr_q;
    assign pick_mask   = in_grant ? (ONE_HOT0 << grant_q) : '0;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IDW)
    ) u_pick (
        .req_i   (req_valid),
        .mask_i  (pick_mask),
        .start_i (pick_start),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            grant_q    <= '0;
            ptr_q      <= '0;
            lock_cnt_q <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (pick_found) begin
                        state_q <= ARB_GRANT;
                        grant_q <= pick_idx;
                    end
                end
                ARB_GRANT: begin
                    if (stay_locked) begin
                        lock_cnt_q <= lock_cnt_q + 8'd1;
                    end else begin
                        lock_cnt_q <= '0;
                        // A withdrawn grant leaves the pointer where it was.
                        if (handshake) begin
                            ptr_q <= next_ptr;
                        end
                        if (pick_found) begin
                            grant_q <= pick_idx;
                        end else begin
                            state_q <= ARB_IDLE;
                        end
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready = '0;
        if (in_grant) begin
            req_ready[grant_q] = 1'b1;
        end
    end

    assign grant_valid = in_grant;
    assign grant_id    = grant_q;
    assign reg_load    = handshake;
    assign reg_in      = handshake ? req_data[int'(grant_q)*WIDTH +: WIDTH] : '0;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: first-grant vector table, scoreboarded write
// sequences and hand-written withdrawal / reset corner cases.
module tb_reg_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_lock;
    logic [63:0] req_data;
    logic [3:0]  req_ready;
    logic        grant_valid;
    logic [1:0]  grant_id;
    logic [15:0] reg_in;
    logic        reg_load;

    always #5 clk = ~clk;

    reg_write_arbiter #(.NUM_REQ(4), .WIDTH(16), .MAX_LOCK(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_lock    (req_lock),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .reg_in      (reg_in),
        .reg_load    (reg_load)
    );

    // External Hack register driven by the arbiter.
    logic [15:0] reg_model = 16'h0;
    always @(posedge clk) begin
        if (reg_load) reg_model <= reg_in;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [1:0]  id;
        logic [15:0] data;
    } wr_t;
    wr_t sb[$];

    int          cnt[4];
    int          done_n[4];
    int          expk[4];
    logic [15:0] base[4];
    logic [3:0]  lock_mask;

    task automatic setup(int id, int n, logic [15:0] b);
        cnt[id]    = n;
        base[id]   = b;
        done_n[id] = 0;
        expk[id]   = 0;
    endtask

    function automatic void push_id(int id);
        wr_t w;
        w.id   = 2'(id);
        w.data = base[id] + 16'(expk[id]);
        expk[id]++;
        sb.push_back(w);
    endfunction

    function automatic bit any_pending();
        bit p = 1'b0;
        for (int i = 0; i < 4; i++) if (cnt[i] > 0) p = 1'b1;
        return p;
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < 4; i++) begin
            req_valid[i]          = (cnt[i] > 0);
            req_lock[i]           = lock_mask[i] && (cnt[i] > 1);
            req_data[i*16 +: 16]  = base[i] + 16'(done_n[i]);
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < 4; i++) setup(i, 0, 16'h0);
        lock_mask = 4'b0;
        sb.delete();
        drive_inputs();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        clear_all();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Requesters behave per handshake; every load pops the scoreboard.
    task automatic run_seq(input int budget, input bit strict, output int cycles);
        int  hs;
        wr_t w;
        cycles = 0;
        while ((any_pending() || sb.size() > 0) && cycles < budget) begin
            drive_inputs();
            @(negedge clk);
            hs = -1;
            for (int i = 0; i < 4; i++) if (req_ready[i] && req_valid[i]) hs = i;
            if (reg_load) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_unexpected: got load id %0d data %h expected no load", grant_id, reg_in);
                end else begin
                    w = sb.pop_front();
                    check("sb_id", 32'(grant_id), 32'(w.id));
                    check("sb_data", 32'(reg_in), 32'(w.data));
                end
            end
            @(posedge clk);
            #1;
            if (hs >= 0) begin
                cnt[hs]--;
                done_n[hs]++;
            end
            cycles++;
        end
        drive_inputs();
        if (strict) begin
            check("sb_left", 32'(sb.size()), 32'd0);
            check("budget_ok", 32'(cycles < budget), 32'd1);
        end
    endtask

    typedef struct {
        logic [3:0] valid;
        logic [1:0] exp_id;
        logic [3:0] exp_ready;
    } vec_t;
    vec_t vt[6];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [15:0] old;
        rst_n = 1'b0;
        clear_all();
        #3;
        check("rst_grant_valid", 32'(grant_valid), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_load", 32'(reg_load), 32'd0);
        check("rst_reg_in", 32'(reg_in), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // First grant after reset goes to the lowest valid index.
        vt[0] = '{4'b0001, 2'd0, 4'b0001};
        vt[1] = '{4'b0110, 2'd1, 4'b0010};
        vt[2] = '{4'b1000, 2'd3, 4'b1000};
        vt[3] = '{4'b1100, 2'd2, 4'b0100};
        vt[4] = '{4'b1111, 2'd0, 4'b0001};
        vt[5] = '{4'b1010, 2'd1, 4'b0010};
        for (int k = 0; k < 6; k++) begin
            do_reset();
            req_valid = vt[k].valid;
            for (int i = 0; i < 4; i++) req_data[i*16 +: 16] = 16'h5000 + 16'(i);
            @(posedge clk);
            @(negedge clk);
            check("tbl_grant_id", 32'(grant_id), 32'(vt[k].exp_id));
            check("tbl_ready", 32'(req_ready), 32'(vt[k].exp_ready));
            check("tbl_load", 32'(reg_load), 32'd1);
            check("tbl_reg_in", 32'(reg_in), 32'(16'h5000 + 16'(vt[k].exp_id)));
        end

        // Single request on requester 2.
        do_reset();
        req_valid = 4'b0100;
        req_data[32 +: 16] = 16'h1234;
        @(posedge clk);
        @(negedge clk);
        check("single_id", 32'(grant_id), 32'd2);
        check("single_ready", 32'(req_ready), 32'b0100);
        check("single_load", 32'(reg_load), 32'd1);
        check("single_reg_in", 32'(reg_in), 32'h1234);
        @(posedge clk);
        #1;
        check("single_reg", 32'(reg_model), 32'h1234);
        req_valid = 4'b0;
        @(negedge clk);
        check("single_idle", 32'(grant_valid), 32'd0);

        // All four at once: 0,1,2,3 back-to-back, then pointer back at 0.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            setup(i, 1, 16'hA000 + 16'(i));
            push_id(i);
        end
        run_seq(30, 1'b1, cyc);
        check("all4_cycles", 32'(cyc), 32'd5);
        check("all4_final_reg", 32'(reg_model), 32'hA003);
        setup(3, 1, 16'hB300);
        setup(0, 1, 16'hB000);
        push_id(0);
        push_id(3);
        run_seq(30, 1'b1, cyc);

        // Lock cap: 8 locked writes, one from requester 3, then the rest.
        do_reset();
        setup(1, 12, 16'h1100);
        setup(3, 2, 16'h3300);
        lock_mask = 4'b0010;
        for (int k = 0; k < 8; k++) push_id(1);
        push_id(3);
        for (int k = 0; k < 4; k++) push_id(1);
        push_id(3);
        run_seq(60, 1'b1, cyc);

        // Requester 0 withdraws during its grant cycle.
        do_reset();
        old = reg_model;
        req_valid = 4'b0101;
        req_data[0 +: 16]  = 16'hD000;
        req_data[32 +: 16] = 16'hD200;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(negedge clk);
        check("wd_id", 32'(grant_id), 32'd0);
        check("wd_ready", 32'(req_ready), 32'b0001);
        check("wd_load", 32'(reg_load), 32'd0);
        check("wd_reg_in", 32'(reg_in), 32'd0);
        @(posedge clk);
        #1;
        check("wd_reg_kept", 32'(reg_model), 32'(old));
        @(negedge clk);
        check("wd_next_id", 32'(grant_id), 32'd2);
        check("wd_next_load", 32'(reg_load), 32'd1);
        check("wd_next_data", 32'(reg_in), 32'hD200);
        @(posedge clk);
        #1 req_valid = 4'b0;
        @(negedge clk);
        check("wd_idle", 32'(grant_valid), 32'd0);

        // Reset in the middle of a locked burst from requester 2.
        do_reset();
        setup(2, 6, 16'hC200);
        lock_mask = 4'b0100;
        for (int k = 0; k < 3; k++) push_id(2);
        run_seq(4, 1'b0, cyc);
        check("mid_pre_sb", 32'(sb.size()), 32'd0);
        check("mid_pre_grant", 32'(grant_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_load", 32'(reg_load), 32'd0);
        check("mid_rst_grant", 32'(grant_valid), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        check("mid_rst_reg_in", 32'(reg_in), 32'd0);
        setup(0, 1, 16'hC000);
        drive_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        push_id(0);
        for (int k = 0; k < 3; k++) push_id(2);
        run_seq(40, 1'b1, cyc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
